// File: rtl/banked_ram_pkg.sv
// Shared types and derived-width helpers for banked_ram and its ram_bank instances.
package banked_ram_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Widths never collapse to zero so single-bank or single-row builds still elaborate.
    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned bank_sel_w(input int unsigned banks);
        return clog2_min1(banks);
    endfunction

    function automatic int unsigned row_w(input int unsigned depth, input int unsigned banks);
        return clog2_min1(depth / banks);
    endfunction

    function automatic int unsigned byte_cnt(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/banked_ram_bank.sv
// ram_bank: one bank of ROWS words, byte-lane write enables, registered read with read enable.
module ram_bank
    import banked_ram_pkg::*;
#(
    parameter int unsigned ROWS   = 8,
    parameter int unsigned ADDR_W = 3,
    parameter int unsigned LANES  = 4,
    parameter int unsigned LANE_W = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_we,
    input  logic                      i_re,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [LANES-1:0]          i_be,
    input  logic [LANES*LANE_W-1:0]   i_wdata,
    output logic [LANES*LANE_W-1:0]   o_rdata
);

    logic [LANES*LANE_W-1:0] r_mem [ROWS];
    logic [LANES*LANE_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][i*LANE_W +: LANE_W] <= i_wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Read register only moves on a read, so the bank holds its last word between reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/banked_ram.sv
// banked_ram: bank-interleaved single-port RAM with byte enables, RD_LAT 1/2 and post-reset zero init.
// Optional per-byte even parity (perr, perr_inj) when PARITY_EN is defined.
module banked_ram
    import banked_ram_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 32,
    parameter int unsigned BANKS  = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cs,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      be,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    output logic                     ready
`ifdef PARITY_EN
    ,
    input  logic                     perr_inj,
    output logic                     perr
`endif
);

    localparam int unsigned NB     = byte_cnt(DATA_W);
`ifdef PARITY_EN
    localparam int unsigned LANE_W = 9;
`else
    localparam int unsigned LANE_W = 8;
`endif
    localparam int unsigned SW     = NB * LANE_W;
    localparam int unsigned ROWS   = DEPTH / BANKS;
    localparam int unsigned AW     = $clog2(DEPTH);
    localparam int unsigned BW     = bank_sel_w(BANKS);
    localparam int unsigned RW     = row_w(DEPTH, BANKS);
    localparam int unsigned BSH    = $clog2(BANKS);

    state_e              r_state;
    logic [RW-1:0]       r_row;
    logic                r_v1;
    logic [BW-1:0]       r_sel;

    logic [BW-1:0]       w_bank;
    logic [RW-1:0]       w_row;
    logic                w_run;
    logic                w_rd_req;
    logic [SW-1:0]       w_enc;
    logic [BANKS-1:0]    w_we;
    logic [BANKS-1:0]    w_re;
    logic [RW-1:0]       w_bank_addr;
    logic [NB-1:0]       w_be;
    logic [SW-1:0]       w_wdata;
    logic [SW-1:0]       w_rd [BANKS];
    logic [SW-1:0]       w_mux;
    logic [DATA_W-1:0]   w_data;

    assign w_row    = RW'(addr >> BSH);
    assign w_bank   = BW'(addr & AW'(BANKS - 1));
    assign w_run    = (r_state == ST_RUN);
    assign ready    = w_run;
    assign w_rd_req = w_run & cs & ~we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_INIT;
            r_row   <= '0;
        end else if (r_state == ST_INIT) begin
            r_row <= r_row + 1'b1;
            if (r_row == RW'(ROWS - 1)) begin
                r_state <= ST_RUN;
            end
        end
    end

    always_comb begin
        w_enc = '0;
        for (int unsigned i = 0; i < NB; i++) begin
            w_enc[i*LANE_W +: 8] = wdata[i*8 +: 8];
`ifdef PARITY_EN
            w_enc[i*LANE_W + 8] = (^wdata[i*8 +: 8]) ^ perr_inj;
`endif
        end
    end

    // Init sweeps one row per cycle across every bank at once; all-zero lanes already carry even parity.
    always_comb begin
        w_we        = '0;
        w_re        = '0;
        w_bank_addr = w_row;
        w_be        = be;
        w_wdata     = w_enc;
        if (r_state == ST_INIT) begin
            w_we        = '1;
            w_bank_addr = r_row;
            w_be        = '1;
            w_wdata     = '0;
        end else begin
            w_we[w_bank] = cs & we;
            w_re[w_bank] = cs & ~we;
        end
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        ram_bank #(
            .ROWS   (ROWS),
            .ADDR_W (RW),
            .LANES  (NB),
            .LANE_W (LANE_W)
        ) u_bank (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_we    (w_we[b]),
            .i_re    (w_re[b]),
            .i_addr  (w_bank_addr),
            .i_be    (w_be),
            .i_wdata (w_wdata),
            .o_rdata (w_rd[b])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_sel <= '0;
        end else begin
            r_v1 <= w_rd_req;
            if (w_rd_req) begin
                r_sel <= w_bank;
            end
        end
    end

    assign w_mux = w_rd[r_sel];

`ifdef PARITY_EN
    logic w_perr;
`endif

    always_comb begin
        w_data = '0;
`ifdef PARITY_EN
        w_perr = 1'b0;
`endif
        for (int unsigned i = 0; i < NB; i++) begin
            w_data[i*8 +: 8] = w_mux[i*LANE_W +: 8];
`ifdef PARITY_EN
            w_perr = w_perr | (^w_mux[i*LANE_W +: LANE_W]);
`endif
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] r_out;
        logic              r_v2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_out <= '0;
                r_v2  <= 1'b0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_out <= w_data;
                end
            end
        end

        assign rdata  = r_out;
        assign rvalid = r_v2;
`ifdef PARITY_EN
        logic r_perr;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_perr <= 1'b0;
            end else if (r_v1) begin
                r_perr <= w_perr;
            end
        end

        assign perr = r_perr;
`endif
    end else begin : g_lat1
        assign rdata  = w_data;
        assign rvalid = r_v1;
`ifdef PARITY_EN
        assign perr   = w_perr;
`endif
    end

endmodule

// File: tb/tb_banked_ram.sv
// Directed bench for banked_ram: RD_LAT=1 and RD_LAT=2 instances share one stimulus stream.
// Parity checks are compiled in when PARITY_EN is defined.
module tb_banked_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cs;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata1, rdata2;
    logic        rvalid1, rvalid2;
    logic        ready1, ready2;
`ifdef PARITY_EN
    logic        perr_inj;
    logic        perr1, perr2;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    banked_ram #(.DATA_W(32), .DEPTH(32), .BANKS(4), .RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata1), .rvalid(rvalid1), .ready(ready1)
`ifdef PARITY_EN
        , .perr_inj(perr_inj), .perr(perr1)
`endif
    );

    banked_ram #(.DATA_W(32), .DEPTH(32), .BANKS(4), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .we(we), .addr(addr), .wdata(wdata), .be(be),
        .rdata(rdata2), .rvalid(rvalid2), .ready(ready2)
`ifdef PARITY_EN
        , .perr_inj(perr_inj), .perr(perr2)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        cs = c; we = w; addr = a; wdata = d; be = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 5'd5, 32'h0, 4'h0);
        step(); step();
        n_cmp++; if (ready1 !== 1'b0 || ready2 !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b/%b exp 0/0", ready1, ready2); end
        n_cmp++; if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin n_err++; $display("FAIL rst_rvalid: got %b/%b exp 0/0", rvalid1, rvalid2); end
        n_cmp++; if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin n_err++; $display("FAIL rst_rdata: got %h/%h exp 0/0", rdata1, rdata2); end
        rst_n = 1'b1;
        n_cmp++; if (ready1 !== 1'b0) begin n_err++; $display("FAIL init_ready1 cyc0: got %b exp 0", ready1); end
        for (int k = 1; k <= 10; k++) begin
            step();
            n_cmp++; if (ready1 !== (k >= 8)) begin n_err++; $display("FAIL init_ready1 cyc%0d: got %b exp %b", k, ready1, k >= 8); end
            n_cmp++; if (ready2 !== (k >= 8)) begin n_err++; $display("FAIL init_ready2 cyc%0d: got %b exp %b", k, ready2, k >= 8); end
            n_cmp++; if (rvalid1 !== (k >= 9)) begin n_err++; $display("FAIL init_rvalid1 cyc%0d: got %b exp %b", k, rvalid1, k >= 9); end
            n_cmp++; if (rvalid2 !== (k >= 10)) begin n_err++; $display("FAIL init_rvalid2 cyc%0d: got %b exp %b", k, rvalid2, k >= 10); end
            if (k >= 9) begin
                n_cmp++; if (rdata1 !== 32'h0) begin n_err++; $display("FAIL init_rdata1 cyc%0d: got %h exp 0", k, rdata1); end
            end
            if (k >= 10) begin
                n_cmp++; if (rdata2 !== 32'h0) begin n_err++; $display("FAIL init_rdata2 cyc%0d: got %h exp 0", k, rdata2); end
            end
        end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
        step(); step();
    endtask

    task automatic test_fill();
        logic [31:0] exp;
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b1, 5'(i), 32'hA5A5_0000 + 32'(i), 4'hF);
            step();
        end
        for (int k = 0; k < 34; k++) begin
            if (k < 32) drive(1'b1, 1'b0, 5'(k), 32'h0, 4'h0);
            else        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
            step();
            if (k < 32) begin
                exp = 32'hA5A5_0000 + 32'(k);
                n_cmp++; if (rvalid1 !== 1'b1 || rdata1 !== exp) begin n_err++; $display("FAIL fill_rd1 addr%0d: got v=%b d=%h exp v=1 d=%h", k, rvalid1, rdata1, exp); end
            end else begin
                n_cmp++; if (rvalid1 !== 1'b0) begin n_err++; $display("FAIL fill_tail1 k%0d: got %b exp 0", k, rvalid1); end
            end
            if (k >= 1 && k <= 32) begin
                exp = 32'hA5A5_0000 + 32'(k - 1);
                n_cmp++; if (rvalid2 !== 1'b1 || rdata2 !== exp) begin n_err++; $display("FAIL fill_rd2 addr%0d: got v=%b d=%h exp v=1 d=%h", k - 1, rvalid2, rdata2, exp); end
            end else begin
                n_cmp++; if (rvalid2 !== 1'b0) begin n_err++; $display("FAIL fill_edge2 k%0d: got %b exp 0", k, rvalid2); end
            end
        end
        // A write between reads must not disturb the held read data.
        drive(1'b1, 1'b1, 5'd31, 32'h0BAD_0BAD, 4'hF);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
        step();
        n_cmp++; if (rdata1 !== 32'hA5A5_001F || rdata2 !== 32'hA5A5_001F) begin n_err++; $display("FAIL hold_rdata: got %h/%h exp a5a5001f", rdata1, rdata2); end
    endtask

    task automatic test_byte_en();
        drive(1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 4'hF); step();
        drive(1'b1, 1'b1, 5'd3, 32'h1234_5678, 4'b0101); step();
        drive(1'b1, 1'b1, 5'd3, 32'h0000_0000, 4'b0000); step();
        drive(1'b1, 1'b0, 5'd3, 32'h0, 4'h0); step();
        n_cmp++; if (rvalid1 !== 1'b1 || rdata1 !== 32'hFF34_FF78) begin n_err++; $display("FAIL be_rd1: got v=%b d=%h exp v=1 d=ff34ff78", rvalid1, rdata1); end
        n_cmp++; if (rvalid2 !== 1'b0) begin n_err++; $display("FAIL be_early2: got %b exp 0", rvalid2); end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0); step();
        n_cmp++; if (rvalid2 !== 1'b1 || rdata2 !== 32'hFF34_FF78) begin n_err++; $display("FAIL be_rd2: got v=%b d=%h exp v=1 d=ff34ff78", rvalid2, rdata2); end
        n_cmp++; if (rvalid1 !== 1'b0) begin n_err++; $display("FAIL be_pulse1: got %b exp 0", rvalid1); end
        step();
    endtask

    task automatic test_raw();
        drive(1'b1, 1'b1, 5'd9, 32'hDEAD_BEEF, 4'hF); step();
        drive(1'b1, 1'b0, 5'd9, 32'h0, 4'h0); step();
        n_cmp++; if (rvalid1 !== 1'b1 || rdata1 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL raw_rd1: got v=%b d=%h exp v=1 d=deadbeef", rvalid1, rdata1); end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0); step();
        n_cmp++; if (rvalid2 !== 1'b1 || rdata2 !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL raw_rd2: got v=%b d=%h exp v=1 d=deadbeef", rvalid2, rdata2); end
        step();
    endtask

    task automatic test_back_to_back();
        logic        op_rd [8];
        logic [4:0]  op_a  [8];
        logic [31:0] op_d  [8];
        op_rd = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        op_a  = '{5'd7, 5'd7, 5'd7, 5'd7, 5'd6, 5'd8, 5'd8, 5'd7};
        op_d  = '{32'h1111_1111, 32'h1111_1111, 32'h2222_2222, 32'h2222_2222,
                  32'hA5A5_0006, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h2222_2222};
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(1'b1, ~op_rd[k], op_a[k], op_d[k], 4'hF);
            else       drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
            step();
            if (k < 8 && op_rd[k]) begin
                n_cmp++; if (rvalid1 !== 1'b1 || rdata1 !== op_d[k]) begin n_err++; $display("FAIL b2b_rd1 op%0d: got v=%b d=%h exp v=1 d=%h", k, rvalid1, rdata1, op_d[k]); end
            end else begin
                n_cmp++; if (rvalid1 !== 1'b0) begin n_err++; $display("FAIL b2b_nv1 op%0d: got %b exp 0", k, rvalid1); end
            end
            if (k >= 1 && k <= 8 && op_rd[k-1]) begin
                n_cmp++; if (rvalid2 !== 1'b1 || rdata2 !== op_d[k-1]) begin n_err++; $display("FAIL b2b_rd2 op%0d: got v=%b d=%h exp v=1 d=%h", k - 1, rvalid2, rdata2, op_d[k-1]); end
            end else begin
                n_cmp++; if (rvalid2 !== 1'b0) begin n_err++; $display("FAIL b2b_nv2 op%0d: got %b exp 0", k - 1, rvalid2); end
            end
        end
    endtask

    task automatic test_reset_mid();
        int waited;
        drive(1'b1, 1'b0, 5'd4, 32'h0, 4'h0); step();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0);
        #1;
        n_cmp++; if (ready1 !== 1'b0 || ready2 !== 1'b0) begin n_err++; $display("FAIL mid_ready: got %b/%b exp 0/0", ready1, ready2); end
        n_cmp++; if (rvalid1 !== 1'b0 || rvalid2 !== 1'b0) begin n_err++; $display("FAIL mid_rvalid: got %b/%b exp 0/0", rvalid1, rvalid2); end
        n_cmp++; if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin n_err++; $display("FAIL mid_rdata: got %h/%h exp 0/0", rdata1, rdata2); end
        for (int k = 0; k < 2; k++) begin
            step();
            n_cmp++; if (rvalid2 !== 1'b0) begin n_err++; $display("FAIL mid_drop2 k%0d: got %b exp 0", k, rvalid2); end
        end
        rst_n = 1'b1;
        waited = 0;
        while (ready1 !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        n_cmp++; if (waited != 8 || ready2 !== 1'b1) begin n_err++; $display("FAIL mid_reinit: got %0d cycles ready2=%b exp 8 cycles ready2=1", waited, ready2); end
        drive(1'b1, 1'b0, 5'd4, 32'h0, 4'h0); step();
        n_cmp++; if (rvalid1 !== 1'b1 || rdata1 !== 32'h0) begin n_err++; $display("FAIL mid_rd1: got v=%b d=%h exp v=1 d=0", rvalid1, rdata1); end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0); step();
        n_cmp++; if (rvalid2 !== 1'b1 || rdata2 !== 32'h0) begin n_err++; $display("FAIL mid_rd2: got v=%b d=%h exp v=1 d=0", rvalid2, rdata2); end
        step();
    endtask

`ifdef PARITY_EN
    task automatic test_parity();
        perr_inj = 1'b1;
        drive(1'b1, 1'b1, 5'd2, 32'h0F0F_1234, 4'hF); step();
        perr_inj = 1'b0;
        drive(1'b1, 1'b0, 5'd2, 32'h0, 4'h0); step();
        n_cmp++; if (rvalid1 !== 1'b1 || perr1 !== 1'b1 || rdata1 !== 32'h0F0F_1234) begin n_err++; $display("FAIL par_inj1: got v=%b p=%b d=%h exp v=1 p=1 d=0f0f1234", rvalid1, perr1, rdata1); end
        drive(1'b1, 1'b1, 5'd2, 32'h0F0F_1234, 4'hF); step();
        n_cmp++; if (rvalid2 !== 1'b1 || perr2 !== 1'b1) begin n_err++; $display("FAIL par_inj2: got v=%b p=%b exp v=1 p=1", rvalid2, perr2); end
        drive(1'b1, 1'b0, 5'd2, 32'h0, 4'h0); step();
        n_cmp++; if (rvalid1 !== 1'b1 || perr1 !== 1'b0) begin n_err++; $display("FAIL par_ok1: got v=%b p=%b exp v=1 p=0", rvalid1, perr1); end
        drive(1'b0, 1'b0, 5'd0, 32'h0, 4'h0); step();
        n_cmp++; if (rvalid2 !== 1'b1 || perr2 !== 1'b0) begin n_err++; $display("FAIL par_ok2: got v=%b p=%b exp v=1 p=0", rvalid2, perr2); end
        step();
    endtask
`endif

    initial begin
`ifdef PARITY_EN
        perr_inj = 1'b0;
`endif
        test_reset();
        test_fill();
        test_byte_en();
        test_raw();
        test_back_to_back();
`ifdef PARITY_EN
        test_parity();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/banked_ram.md
# banked_ram

Parametrised, single-port, bank-interleaved synchronous RAM with byte enables, a configurable read latency and a self-clearing init sequence after reset. It is the general successor to the fixed 8x8/16x16/32x32 RAM composites and replaces hand-instantiated chip-select trees with one block. It sits directly on the local memory bus. Read and write data are separate, so there is no tri-state.

## Interface
- DATA_W, 32: word width in bits; must be a multiple of 8.
- DEPTH, 32: number of words; must be a power of 2.
- BANKS, 4: number of interleaved banks; must be a power of 2, with BANKS ≤ DEPTH.
- RD_LAT, 1: read latency in cycles; legal values are 1 and 2.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cs  in  1  request strobe; sampled only while ready=1.
- we  in  1  1 = write, 0 = read.
- addr  in  clog2(DEPTH)  word address.
- wdata  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables for writes; ignored on reads.
- rdata  out  DATA_W  read data; holds its last value between reads.
- rvalid  out  1  one-cycle pulse marking valid rdata.
- ready  out  1  high once init is complete; requests are accepted only while it is high.

## Operation
- Address split: addr[clog2(BANKS)-1:0] selects the bank; the upper bits select the row (ROWS = DEPTH/BANKS). Consecutive addresses therefore hit different banks.
- FSM states are INIT and RUN.
  - Reset forces INIT with the row counter at 0.
  - In INIT, every cycle writes all-zero, with all bytes enabled, into the current row of every bank, then increments the counter.
  - After row ROWS-1 is written, the FSM moves to RUN. RUN is left only by reset.
- In INIT, ready=0 and cs is ignored: no write, no rvalid.
- Write (RUN, cs=1, we=1): each byte lane i with be[i]=1 is updated. Lanes with be[i]=0 are unchanged. be=0 is a legal no-op. No rvalid is produced.
- Read (RUN, cs=1, we=0): only the selected bank is read. rdata is the word at that address; rvalid pulses once.
- Back-to-back requests are legal every cycle, in any mix of reads and writes.
- A read in the cycle after a write to the same address returns the new data, at both RD_LAT values.
- Reset mid-operation, asynchronously:
  - rdata=0, rvalid=0, ready=0.
  - In-flight reads are dropped.
  - Init restarts from row 0.
  - Memory contents are not guaranteed until ready rises again.
- Reset values: rdata=0, rvalid=0, ready=0, FSM=INIT, row counter=0.

## Timing
- Request presented in cycle t (sampled at the rising edge ending cycle t) → rdata/rvalid valid in cycle t+RD_LAT.
- RD_LAT=2 adds one output register stage. The read pipeline is fully pipelined, giving one read per cycle at either latency.
- Write data is in the array and readable from cycle t+1.
- Init takes ROWS cycles: with cycle 0 as the first cycle after rst_n deasserts, ready=1 from cycle ROWS.
- Rule: a request with cs=1 in the same cycle that ready first goes high is accepted.

## Configuration
- PARITY_EN defined:
  - Each byte is stored with an even-parity bit.
  - The init sequence writes parity consistent with zero data.
  - Output port perr (1 bit) is valid alongside rvalid and is 1 if any byte of the read word fails parity. perr resets to 0.
  - Input perr_inj (1 bit): a write with perr_inj=1 stores inverted parity for every enabled byte.
- PARITY_EN undefined: perr and perr_inj do not exist, and storage is exactly DATA_W bits per word.

## Structure
- Shared package banked_ram_pkg holds:
  - the FSM state enum (INIT, RUN);
  - helper functions for derived widths (bank-select width, row width, byte count).
- Sub-module ram_bank is one bank of ROWS words:
  - synchronous write with byte enables;
  - registered read with read enable.
- The top level instantiates BANKS copies of ram_bank via generate. It owns the INIT FSM and row counter, the bank decode, the read-bank select pipeline, the optional output register, and rvalid.

## Test plan
- Reset, then hold cs=1, we=0 throughout. With defaults, ready=0 for cycles 0-7 and 1 from cycle 8. No rvalid occurs before cycle 8. A read of addr 5 issued in cycle 8 returns rdata=0 in cycle 9.
- Write 0xA5A5_0000+i to addr i for i=0..31, back to back, then read 0..31 back to back. Expect 32 consecutive rvalid pulses with matching data, first at RD_LAT cycles after the first read.
- Write 0xFFFF_FFFF to addr 3, then write 0x1234_5678 with be=4'b0101, then read. Expect 0xFF34_FF78.
- Write 0xDEAD_BEEF to addr 9, then read addr 9 in the next cycle. Expect 0xDEAD_BEEF in that cycle + RD_LAT, run at both RD_LAT=1 and RD_LAT=2.
- Assert rst_n=0 in the cycle after a read request. The rvalid for that read never appears, ready drops immediately, and a subsequent read returns 0 after re-init.
- PARITY_EN: write addr 2 with perr_inj=1, then read it: expect perr=1 with rvalid. Write addr 2 normally, then read: expect perr=0.
